// File: rtl/banked_reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module : banked_reg_file_pkg
// Brief  : Shared types and register-map constants for the banked register file
// Rev    : 1.0 - initial release
// ============================================================================
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

package banked_reg_file_pkg;

    typedef logic [`DATA_WIDTH-1:0] data_t;

    typedef enum logic [1:0] {
        ALU_OUT          = 2'd0,
        LSU_OUT          = 2'd1,
        IMMEDIATE        = 2'd2,
        VECTOR_TO_SCALAR = 2'd3
    } reg_input_mux_t;

    localparam int unsigned ZERO_REG       = 0;
    localparam int unsigned THREAD_ID_REG  = 1;
    localparam int unsigned BLOCK_ID_REG   = 2;
    localparam int unsigned BLOCK_SIZE_REG = 3;
    localparam int unsigned FIRST_GP_REG   = 4;

endpackage

`default_nettype wire

// File: rtl/banked_reg_file_if.sv
`default_nettype none
// ============================================================================
// Module : banked_reg_file_if
// Brief  : Read / reserve / writeback bus of the banked register file
// Rev    : 1.0 - initial release
// ============================================================================
interface banked_reg_file_if
    import banked_reg_file_pkg::*;
#(
    parameter int NUM_WARPS        = 4,
    parameter int THREADS_PER_WARP = 32,
    parameter int NUM_REGS         = 32
);
    localparam int WW = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int RW = $clog2(NUM_REGS);

    logic                                rd_valid;
    logic                                rd_ready;
    logic [WW-1:0]                       rd_warp;
    logic [RW-1:0]                       rd_rs1;
    logic [RW-1:0]                       rd_rs2;
    logic                                resp_valid;
    data_t [THREADS_PER_WARP-1:0]        rs1;
    data_t [THREADS_PER_WARP-1:0]        rs2;
    logic                                rsv_valid;
    logic [WW-1:0]                       rsv_warp;
    logic [RW-1:0]                       rsv_rd;
    logic                                wr_valid;
    logic [WW-1:0]                       wr_warp;
    logic [RW-1:0]                       wr_rd;
    logic [THREADS_PER_WARP-1:0]         wr_mask;
    reg_input_mux_t                      wr_src;
    data_t [THREADS_PER_WARP-1:0]        alu_out;
    data_t [THREADS_PER_WARP-1:0]        lsu_out;
    data_t                               wr_imm;
    data_t [NUM_WARPS-1:0]               block_id;
    data_t                               block_size;
    logic [NUM_WARPS-1:0]                busy_any;

    modport master (
        output rd_valid, rd_warp, rd_rs1, rd_rs2,
        output rsv_valid, rsv_warp, rsv_rd,
        output wr_valid, wr_warp, wr_rd, wr_mask, wr_src,
        output alu_out, lsu_out, wr_imm, block_id, block_size,
        input  rd_ready, resp_valid, rs1, rs2, busy_any
    );

    modport slave (
        input  rd_valid, rd_warp, rd_rs1, rd_rs2,
        input  rsv_valid, rsv_warp, rsv_rd,
        input  wr_valid, wr_warp, wr_rd, wr_mask, wr_src,
        input  alu_out, lsu_out, wr_imm, block_id, block_size,
        output rd_ready, resp_valid, rs1, rs2, busy_any
    );

endinterface

`default_nettype wire

// File: rtl/banked_reg_file_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : reg_scoreboard
// Brief  : Per-warp busy bits with reserve/writeback priority and read hazard
// Rev    : 1.0 - initial release
// ============================================================================
module reg_scoreboard
    import banked_reg_file_pkg::*;
#(
    parameter  int NUM_WARPS = 4,
    parameter  int NUM_REGS  = 32,
    localparam int WW        = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1,
    localparam int RW        = $clog2(NUM_REGS)
) (
    input  wire logic                 clk,
    input  wire logic                 reset_n,
    input  wire logic                 rsv_valid_i,
    input  wire logic [WW-1:0]        rsv_warp_i,
    input  wire logic [RW-1:0]        rsv_rd_i,
    input  wire logic                 wr_valid_i,
    input  wire logic [WW-1:0]        wr_warp_i,
    input  wire logic [RW-1:0]        wr_rd_i,
    input  wire logic [WW-1:0]        rd_warp_i,
    input  wire logic [RW-1:0]        rd_rs1_i,
    input  wire logic [RW-1:0]        rd_rs2_i,
    output logic                      rd_ready_o,
    output logic [NUM_WARPS-1:0]      busy_any_o
);

    localparam logic [RW-1:0] GP_BASE = RW'(FIRST_GP_REG);

    logic [NUM_WARPS-1:0][NUM_REGS-1:0] busy_q;
    logic [NUM_WARPS-1:0][NUM_REGS-1:0] busy_d;
    logic [NUM_REGS-1:0]                w_rd_row;
    logic                               w_rd_wok;
    logic                               w_wr_wok;
    logic                               w_rsv_wok;

    assign w_rd_wok  = 32'(rd_warp_i)  < NUM_WARPS;
    assign w_wr_wok  = 32'(wr_warp_i)  < NUM_WARPS;
    assign w_rsv_wok = 32'(rsv_warp_i) < NUM_WARPS;

    // Set is applied after clear so a same-cycle reservation wins.
    always_comb begin
        busy_d = busy_q;
        if (wr_valid_i && w_wr_wok) begin
            busy_d[wr_warp_i][wr_rd_i] = 1'b0;
        end
        if (rsv_valid_i && w_rsv_wok && (rsv_rd_i >= GP_BASE)) begin
            busy_d[rsv_warp_i][rsv_rd_i] = 1'b1;
        end
    end

    always_comb begin
        w_rd_row = '0;
        if (w_rd_wok) begin
            w_rd_row = busy_q[rd_warp_i];
            if (wr_valid_i && w_wr_wok && (wr_warp_i == rd_warp_i)) begin
                w_rd_row[wr_rd_i] = 1'b0;
            end
        end
    end

    assign rd_ready_o = ~(w_rd_row[rd_rs1_i] | w_rd_row[rd_rs2_i]);

    for (genvar w = 0; w < NUM_WARPS; w++) begin : g_any
        assign busy_any_o[w] = |busy_q[w];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/banked_reg_file.sv
`default_nettype none
// ============================================================================
// Module : banked_reg_file
// Brief  : Per-warp, per-lane register file with special registers, bypass
//          and a reservation scoreboard gating operand reads
// Rev    : 1.0 - initial release
// ============================================================================
module banked_reg_file
    import banked_reg_file_pkg::*;
#(
    parameter int NUM_WARPS        = 4,
    parameter int THREADS_PER_WARP = 32,
    parameter int NUM_REGS         = 32,
    parameter int DATA_WIDTH       = `DATA_WIDTH
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    banked_reg_file_if.slave   bus
);

    localparam int WW      = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int RW      = $clog2(NUM_REGS);
    localparam int TPW     = THREADS_PER_WARP;
    localparam int GP_REGS = NUM_REGS - FIRST_GP_REG;
    localparam logic [RW-1:0] GP_BASE = RW'(FIRST_GP_REG);

    typedef logic [DATA_WIDTH-1:0] word_t;

    word_t                  mem_q [NUM_WARPS][GP_REGS][TPW];
    logic                   resp_valid_q;
    data_t [TPW-1:0]        rs1_q;
    data_t [TPW-1:0]        rs2_q;
    logic                   resp_valid_d;
    data_t [TPW-1:0]        rs1_d;
    data_t [TPW-1:0]        rs2_d;

    logic                   w_rd_ready;
    logic                   w_rd_accept;
    logic                   w_rd_wok;
    logic                   w_wr_wok;
    logic                   w_wr_en;
    logic [RW-1:0]          w_wr_idx;
    logic [WW-1:0]          w_rd_warp_s;
    logic [RW-1:0]          w_rs1_idx;
    logic [RW-1:0]          w_rs2_idx;
    logic                   w_byp1;
    logic                   w_byp2;
    data_t                  w_bid;
    data_t [TPW-1:0]        w_wdata;
    data_t [TPW-1:0]        w_rs1_new;
    data_t [TPW-1:0]        w_rs2_new;

    function automatic data_t read_mux(
        input logic [RW-1:0] r,
        input data_t         tid,
        input data_t         bid,
        input data_t         bsz,
        input data_t         mem,
        input logic          byp,
        input data_t         byp_val
    );
        if (r == RW'(ZERO_REG))            return '0;
        else if (r == RW'(THREAD_ID_REG))  return tid;
        else if (r == RW'(BLOCK_ID_REG))   return bid;
        else if (r == RW'(BLOCK_SIZE_REG)) return bsz;
        else if (byp)                      return byp_val;
        else                               return mem;
    endfunction

    reg_scoreboard #(
        .NUM_WARPS (NUM_WARPS),
        .NUM_REGS  (NUM_REGS)
    ) u_scoreboard (
        .clk         (clk),
        .reset_n     (reset_n),
        .rsv_valid_i (bus.rsv_valid),
        .rsv_warp_i  (bus.rsv_warp),
        .rsv_rd_i    (bus.rsv_rd),
        .wr_valid_i  (bus.wr_valid),
        .wr_warp_i   (bus.wr_warp),
        .wr_rd_i     (bus.wr_rd),
        .rd_warp_i   (bus.rd_warp),
        .rd_rs1_i    (bus.rd_rs1),
        .rd_rs2_i    (bus.rd_rs2),
        .rd_ready_o  (w_rd_ready),
        .busy_any_o  (bus.busy_any)
    );

    assign bus.rd_ready = w_rd_ready;
    assign w_rd_accept  = bus.rd_valid && w_rd_ready;
    assign w_rd_wok     = 32'(bus.rd_warp) < NUM_WARPS;
    assign w_wr_wok     = 32'(bus.wr_warp) < NUM_WARPS;

    // Special registers are never stored, and vector-to-scalar carries no data.
    assign w_wr_en  = bus.wr_valid && w_wr_wok && (bus.wr_rd >= GP_BASE)
                   && (bus.wr_src != VECTOR_TO_SCALAR);
    assign w_wr_idx = bus.wr_rd - GP_BASE;

    always_comb begin
        for (int l = 0; l < TPW; l++) begin
            case (bus.wr_src)
                ALU_OUT: w_wdata[l] = bus.alu_out[l];
                LSU_OUT: w_wdata[l] = bus.lsu_out[l];
                default: w_wdata[l] = bus.wr_imm;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            for (int l = 0; l < TPW; l++) begin
                if (bus.wr_mask[l]) begin
                    mem_q[bus.wr_warp][w_wr_idx][l] <= word_t'(w_wdata[l]);
                end
            end
        end
    end

    // Clamp indices so special-register and bad-warp reads never address past the array.
    assign w_rd_warp_s = w_rd_wok ? bus.rd_warp : '0;
    assign w_rs1_idx   = (bus.rd_rs1 >= GP_BASE) ? (bus.rd_rs1 - GP_BASE) : '0;
    assign w_rs2_idx   = (bus.rd_rs2 >= GP_BASE) ? (bus.rd_rs2 - GP_BASE) : '0;
    assign w_bid       = bus.block_id[w_rd_warp_s];
    assign w_byp1      = w_wr_en && (bus.wr_warp == bus.rd_warp) && (bus.wr_rd == bus.rd_rs1);
    assign w_byp2      = w_wr_en && (bus.wr_warp == bus.rd_warp) && (bus.wr_rd == bus.rd_rs2);

    for (genvar l = 0; l < TPW; l++) begin : g_lane
        data_t w_tid;
        assign w_tid = data_t'(32'(w_rd_warp_s) * 32'(TPW) + 32'(l));
        assign w_rs1_new[l] = read_mux(bus.rd_rs1, w_tid, w_bid, bus.block_size,
                                       data_t'(mem_q[w_rd_warp_s][w_rs1_idx][l]),
                                       w_byp1 & bus.wr_mask[l], w_wdata[l]);
        assign w_rs2_new[l] = read_mux(bus.rd_rs2, w_tid, w_bid, bus.block_size,
                                       data_t'(mem_q[w_rd_warp_s][w_rs2_idx][l]),
                                       w_byp2 & bus.wr_mask[l], w_wdata[l]);
    end

    always_comb begin
        resp_valid_d = w_rd_accept;
        rs1_d        = rs1_q;
        rs2_d        = rs2_q;
        if (w_rd_accept) begin
            rs1_d = w_rd_wok ? w_rs1_new : '0;
            rs2_d = w_rd_wok ? w_rs2_new : '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid_q <= 1'b0;
            rs1_q        <= '0;
            rs2_q        <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            rs1_q        <= rs1_d;
            rs2_q        <= rs2_d;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.rs1        = rs1_q;
    assign bus.rs2        = rs2_q;

endmodule

`default_nettype wire

// File: tb/tb_banked_reg_file.sv
`default_nettype none
// ============================================================================
// Module : tb_banked_reg_file
// Brief  : Directed table-driven bench for banked_reg_file (2 warps x 4 lanes)
// Rev    : 1.0 - initial release
// ============================================================================
module tb_banked_reg_file;
    import banked_reg_file_pkg::*;

    typedef logic [3:0][31:0] lanes_t;

    typedef struct packed {
        logic           rd_valid;
        logic           rd_warp;
        logic [4:0]     rs1;
        logic [4:0]     rs2;
        logic           rsv_valid;
        logic           rsv_warp;
        logic [4:0]     rsv_rd;
        logic           wr_valid;
        logic           wr_warp;
        logic [4:0]     wr_rd;
        logic [3:0]     wr_mask;
        reg_input_mux_t wr_src;
        logic [31:0]    imm;
        logic           chk_ready;
        logic           exp_ready;
        logic           exp_resp;
        logic [1:0]     exp_busy;
        logic           chk_data;
        lanes_t         exp_rs1;
        lanes_t         exp_rs2;
    } vec_t;

    logic clk;
    logic reset_n;
    int   n_cmp;
    int   n_fail;
    vec_t tbl[$];

    banked_reg_file_if #(.NUM_WARPS(2), .THREADS_PER_WARP(4), .NUM_REGS(32)) bus ();

    banked_reg_file #(
        .NUM_WARPS        (2),
        .THREADS_PER_WARP (4),
        .NUM_REGS         (32),
        .DATA_WIDTH       (32)
    ) u_dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic lanes_t L(input int a, input int b, input int c, input int d);
        lanes_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    function automatic vec_t rd(input vec_t x, input logic w, input int a, input int b);
        x.rd_valid = 1'b1; x.rd_warp = w; x.rs1 = 5'(a); x.rs2 = 5'(b);
        return x;
    endfunction

    function automatic vec_t wr(input vec_t x, input logic w, input int r, input logic [3:0] m,
                                input reg_input_mux_t s, input int imm);
        x.wr_valid = 1'b1; x.wr_warp = w; x.wr_rd = 5'(r); x.wr_mask = m; x.wr_src = s; x.imm = imm;
        return x;
    endfunction

    function automatic vec_t rsv(input vec_t x, input logic w, input int r);
        x.rsv_valid = 1'b1; x.rsv_warp = w; x.rsv_rd = 5'(r);
        return x;
    endfunction

    function automatic vec_t ex(input vec_t x, input logic ck, input logic rdy, input logic resp,
                                input logic [1:0] busy);
        x.chk_ready = ck; x.exp_ready = rdy; x.exp_resp = resp; x.exp_busy = busy;
        return x;
    endfunction

    function automatic vec_t dat(input vec_t x, input lanes_t a, input lanes_t b);
        x.chk_data = 1'b1; x.exp_rs1 = a; x.exp_rs2 = b;
        return x;
    endfunction

    task automatic chk(input string nm, input int row, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %h expected %h", nm, row, got, exp);
        end
    endtask

    task automatic apply(input vec_t x);
        bus.rd_valid  = x.rd_valid;
        bus.rd_warp   = x.rd_warp;
        bus.rd_rs1    = x.rs1;
        bus.rd_rs2    = x.rs2;
        bus.rsv_valid = x.rsv_valid;
        bus.rsv_warp  = x.rsv_warp;
        bus.rsv_rd    = x.rsv_rd;
        bus.wr_valid  = x.wr_valid;
        bus.wr_warp   = x.wr_warp;
        bus.wr_rd     = x.wr_rd;
        bus.wr_mask   = x.wr_mask;
        bus.wr_src    = x.wr_src;
        bus.wr_imm    = x.imm;
    endtask

    task automatic run_row(input int i, input vec_t x);
        @(negedge clk);
        apply(x);
        #1;
        if (x.chk_ready) chk("rd_ready", i, 128'(bus.rd_ready), 128'(x.exp_ready));
        @(posedge clk);
        #1;
        chk("resp_valid", i, 128'(bus.resp_valid), 128'(x.exp_resp));
        chk("busy_any", i, 128'(bus.busy_any), 128'(x.exp_busy));
        if (x.chk_data) begin
            chk("rs1", i, bus.rs1, x.exp_rs1);
            chk("rs2", i, bus.rs2, x.exp_rs2);
        end
    endtask

    initial begin
        vec_t z;
        z = '0;
        n_cmp = 0;
        n_fail = 0;
        reset_n = 1'b0;
        apply(z);
        bus.alu_out    = L(1, 2, 3, 4);
        bus.lsu_out    = L('h100, 'h101, 'h102, 'h103);
        bus.block_id   = {32'd7, 32'd3};
        bus.block_size = 32'd64;

        tbl.push_back(dat(ex(rd(z, 1, 1, 2), 1, 1, 1, 2'b00), L(4, 5, 6, 7), L(7, 7, 7, 7)));
        tbl.push_back(dat(ex(z, 0, 0, 0, 2'b00), L(4, 5, 6, 7), L(7, 7, 7, 7)));
        tbl.push_back(ex(wr(z, 0, 5, 4'b1111, IMMEDIATE, 0), 0, 0, 0, 2'b00));
        tbl.push_back(ex(wr(z, 0, 5, 4'b0101, IMMEDIATE, 'h2A), 0, 0, 0, 2'b00));
        tbl.push_back(dat(ex(rd(z, 0, 5, 1), 1, 1, 1, 2'b00), L('h2A, 0, 'h2A, 0), L(0, 1, 2, 3)));
        tbl.push_back(ex(rsv(z, 0, 9), 0, 0, 0, 2'b01));
        tbl.push_back(ex(rd(z, 0, 9, 0), 1, 0, 0, 2'b01));
        tbl.push_back(dat(ex(wr(rd(z, 0, 9, 0), 0, 9, 4'b1111, ALU_OUT, 0), 1, 1, 1, 2'b00),
                          L(1, 2, 3, 4), L(0, 0, 0, 0)));
        tbl.push_back(ex(wr(rsv(z, 1, 6), 1, 6, 4'b1111, IMMEDIATE, 'h11), 0, 0, 0, 2'b10));
        tbl.push_back(ex(wr(z, 1, 6, 4'b1111, VECTOR_TO_SCALAR, 0), 0, 0, 0, 2'b00));
        tbl.push_back(ex(rsv(wr(z, 0, 2, 4'b1111, IMMEDIATE, 'hFF), 0, 2), 0, 0, 0, 2'b00));
        tbl.push_back(dat(ex(rd(z, 0, 2, 3), 1, 1, 1, 2'b00), L(3, 3, 3, 3), L(64, 64, 64, 64)));
        tbl.push_back(dat(ex(wr(rd(z, 0, 5, 9), 0, 5, 4'b1010, LSU_OUT, 0), 1, 1, 1, 2'b00),
                          L('h2A, 'h101, 'h2A, 'h103), L(1, 2, 3, 4)));
        tbl.push_back(ex(rsv(z, 0, 5), 0, 0, 0, 2'b01));
        tbl.push_back(dat(ex(wr(rd(z, 0, 5, 0), 0, 5, 4'b1111, VECTOR_TO_SCALAR, 'h77), 1, 1, 1, 2'b00),
                          L('h2A, 'h101, 'h2A, 'h103), L(0, 0, 0, 0)));
        tbl.push_back(dat(ex(rd(z, 0, 5, 0), 1, 1, 1, 2'b00), L('h2A, 'h101, 'h2A, 'h103), L(0, 0, 0, 0)));
        tbl.push_back(ex(wr(z, 0, 7, 4'b1111, IMMEDIATE, 'h55), 0, 0, 0, 2'b00));
        tbl.push_back(ex(wr(z, 1, 5, 4'b1111, IMMEDIATE, 'h99), 0, 0, 0, 2'b00));
        tbl.push_back(dat(ex(rd(z, 1, 5, 6), 1, 1, 1, 2'b00), L('h99, 'h99, 'h99, 'h99), L('h11, 'h11, 'h11, 'h11)));
        tbl.push_back(dat(ex(rd(z, 0, 7, 5), 1, 1, 1, 2'b00), L('h55, 'h55, 'h55, 'h55),
                          L('h2A, 'h101, 'h2A, 'h103)));
        tbl.push_back(ex(rsv(z, 0, 12), 0, 0, 0, 2'b01));
        tbl.push_back(ex(rd(z, 0, 0, 12), 1, 0, 0, 2'b01));
        tbl.push_back(ex(rd(z, 1, 0, 12), 1, 1, 1, 2'b01));
        tbl.push_back(ex(wr(z, 0, 12, 4'b1111, ALU_OUT, 0), 0, 0, 0, 2'b00));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset resp_valid", -1, 128'(bus.resp_valid), 128'(0));
        chk("reset busy_any", -1, 128'(bus.busy_any), 128'(0));
        chk("reset rs1", -1, bus.rs1, 128'(0));
        chk("reset rs2", -1, bus.rs2, 128'(0));
        @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < tbl.size(); i++) begin
            run_row(i, tbl[i]);
        end

        // Async reset in the middle of a read response
        run_row(100, ex(rsv(z, 1, 4), 0, 0, 0, 2'b10));
        run_row(101, dat(ex(rd(z, 0, 7, 0), 1, 1, 1, 2'b10), L('h55, 'h55, 'h55, 'h55), L(0, 0, 0, 0)));
        #2;
        reset_n = 1'b0;
        #1;
        chk("async resp_valid", 102, 128'(bus.resp_valid), 128'(0));
        chk("async busy_any", 102, 128'(bus.busy_any), 128'(0));
        chk("async rs1", 102, bus.rs1, 128'(0));
        @(negedge clk);
        apply(z);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            chk("post-reset resp_valid", 103 + k, 128'(bus.resp_valid), 128'(0));
        end
        run_row(106, dat(ex(rd(z, 0, 7, 1), 1, 1, 1, 2'b00), L('h55, 'h55, 'h55, 'h55), L(0, 1, 2, 3)));
        run_row(107, dat(ex(z, 0, 0, 0, 2'b00), L('h55, 'h55, 'h55, 'h55), L(0, 1, 2, 3)));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
